branch_predictor: RTL and testbench

Parametrised branch-prediction unit for the RV64 fetch stage. It combines a BHT of saturating counters with a circular return-address stack (RAS) and produces a registered prediction one cycle after each fetch lookup. It is trained from execute and restores its RAS on misprediction. After reset, a self-initialisation FSM clears the BHT so no large async-reset array is needed.

---
 rtl/bp_pkg.sv | 24 ++
 rtl/bp_ras.sv | 75 +++++++
 rtl/branch_predictor.sv | 193 +++++++++++++++++++
 tb/tb_branch_predictor.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor.
package bp_pkg;

    localparam int unsigned BP_CTR_MAX_W = 4;

    // Widest supported counter; instances truncate to their CTR_BITS.
    typedef logic [BP_CTR_MAX_W-1:0] bp_ctr_t;

    typedef enum logic {
        BP_INIT = 1'b0,
        BP_RUN  = 1'b1
    } bp_state_e;

    // Weakly-not-taken value: 2^(ctr_bits-1) - 1.
    function automatic bp_ctr_t bp_wnt(input int unsigned ctr_bits);
        return bp_ctr_t'((32'd1 << (ctr_bits - 32'd1)) - 32'd1);
    endfunction

    // Index width for a table of the given number of entries.
    function automatic int unsigned bp_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

endpackage

// File: rtl/bp_ras.sv
// Circular return-address stack with push/pop/restore; built only when BP_RAS_EN is defined.
module bp_ras
    import bp_pkg::*;
#(
    parameter int unsigned RAS_SIZE = 8,
    parameter int unsigned ADDR_W   = 48
) (
    input  logic                        clk,
    input  logic                        n_reset,
    input  logic                        push,
    input  logic                        pop,
    input  logic                        restore,
    input  logic [ADDR_W-1:0]           push_data,
    input  logic [$clog2(RAS_SIZE)-1:0] restore_ptr,
    input  logic [$clog2(RAS_SIZE):0]   restore_cnt,
    output logic [ADDR_W-1:0]           top_c,
    output logic [$clog2(RAS_SIZE):0]   cnt,
    output logic [$clog2(RAS_SIZE)-1:0] ptr_nxt_c,
    output logic [$clog2(RAS_SIZE):0]   cnt_nxt_c
);

    localparam int unsigned PTR_W = $clog2(RAS_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_SIZE);

    logic [ADDR_W-1:0] mem [RAS_SIZE];
    logic [PTR_W-1:0]  ptr_q;
    logic [PTR_W-1:0]  base;
    logic [CNT_W-1:0]  cnt_q;

    assign top_c = mem[ptr_q];
    assign cnt   = cnt_q;

    // Next pointer/occupancy: restore wins, otherwise pop then push.
    always_comb begin
        base      = ptr_q;
        ptr_nxt_c = ptr_q;
        cnt_nxt_c = cnt_q;
        if (restore) begin
            ptr_nxt_c = restore_ptr;
            cnt_nxt_c = restore_cnt;
        end else begin
            if (pop && (cnt_q != '0)) begin
                base      = ptr_q - PTR_W'(1);
                cnt_nxt_c = cnt_q - CNT_W'(1);
            end
            ptr_nxt_c = base;
            if (push) begin
                ptr_nxt_c = base + PTR_W'(1);
                if (cnt_nxt_c != CNT_FULL) begin
                    cnt_nxt_c = cnt_nxt_c + CNT_W'(1);
                end
            end
        end
    end

    // Stack storage; a push into a full stack overwrites the oldest slot.
    always_ff @(posedge clk) begin
        if (push && !restore) begin
            mem[ptr_nxt_c] <= push_data;
        end
    end

    // Top pointer and occupancy.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_nxt_c;
            cnt_q <= cnt_nxt_c;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Fetch-stage branch predictor: BHT of saturating counters plus optional RAS (BP_RAS_EN).
module branch_predictor
    import bp_pkg::*;
#(
    parameter int unsigned BHT_SIZE = 256,
    parameter int unsigned CTR_BITS = 2,
    parameter int unsigned RAS_SIZE = 8,
    parameter int unsigned ADDR_W   = 48
) (
    input  logic                        clk,
    input  logic                        n_reset,
    output logic                        bp_ready,
    input  logic                        f_valid,
    input  logic [ADDR_W-1:0]           f_pc,
    input  logic                        f_is_br,
    input  logic                        f_is_call,
    input  logic                        f_is_ret,
    input  logic [ADDR_W-1:0]           f_target,
    output logic                        p_valid,
    output logic                        p_taken,
    output logic [ADDR_W-1:0]           p_target,
    output logic [$clog2(RAS_SIZE)-1:0] p_ras_ptr,
    output logic [$clog2(RAS_SIZE):0]   p_ras_cnt,
    input  logic                        u_valid,
    input  logic [ADDR_W-1:0]           u_pc,
    input  logic                        u_is_br,
    input  logic                        u_taken,
    input  logic                        u_mispredict,
    input  logic [$clog2(RAS_SIZE)-1:0] u_ras_ptr,
    input  logic [$clog2(RAS_SIZE):0]   u_ras_cnt
);

    localparam int unsigned IDX_W = bp_idx_w(BHT_SIZE);
    localparam int unsigned PTR_W = $clog2(RAS_SIZE);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'(bp_wnt(CTR_BITS));
    localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
    localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(BHT_SIZE - 1);

    bp_state_e           state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CTR_BITS-1:0] bht [BHT_SIZE];
    logic                bht_we;
    logic [IDX_W-1:0]    bht_waddr;
    logic [CTR_BITS-1:0] bht_wdata;
    logic [IDX_W-1:0]    f_idx, u_idx;
    logic                f_ctr_msb;
    logic [CTR_BITS-1:0] u_ctr, u_ctr_nxt;
    logic                lookup, upd;
    logic [ADDR_W-1:0]   seq_pc;
    logic                pred_taken;
    logic [ADDR_W-1:0]   pred_target;
    logic                ras_push, ras_pop, ras_restore;
    logic [ADDR_W-1:0]   ras_top_c;
    logic [CNT_W-1:0]    ras_cnt;
    logic [PTR_W-1:0]    ras_ptr_nxt_c;
    logic [CNT_W-1:0]    ras_cnt_nxt_c;
    logic                unused_pc;

    assign f_idx     = f_pc[IDX_W+1:2];
    assign u_idx     = u_pc[IDX_W+1:2];
    assign f_ctr_msb = bht[f_idx][CTR_BITS-1];
    assign u_ctr     = bht[u_idx];
    assign seq_pc    = f_pc + ADDR_W'(4);
    assign lookup    = (state_q == BP_RUN) && f_valid && !u_mispredict;
    assign upd       = (state_q == BP_RUN) && u_valid && u_is_br;
    assign ras_restore = (state_q == BP_RUN) && u_mispredict;
    assign unused_pc = ^{u_pc[ADDR_W-1:IDX_W+2], u_pc[1:0]};

    // Saturating counter training value.
    always_comb begin
        u_ctr_nxt = u_ctr;
        if (u_taken && (u_ctr != CTR_MAX)) begin
            u_ctr_nxt = u_ctr + CTR_BITS'(1);
        end else if (!u_taken && (u_ctr != '0)) begin
            u_ctr_nxt = u_ctr - CTR_BITS'(1);
        end
    end

    // Init/run FSM: sweep the BHT to WNT, then accept training writes.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        bht_we    = 1'b0;
        bht_waddr = u_idx;
        bht_wdata = u_ctr_nxt;
        case (state_q)
            BP_INIT: begin
                bht_we    = 1'b1;
                bht_waddr = idx_q;
                bht_wdata = CTR_WNT;
                idx_d     = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = BP_RUN;
                end
            end
            BP_RUN: begin
                bht_we = upd;
            end
            default: begin
                state_d = BP_INIT;
            end
        endcase
    end

    // FSM state and init index.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= BP_INIT;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // BHT array, cleared by the init sweep rather than by reset.
    always_ff @(posedge clk) begin
        if (bht_we) begin
            bht[bht_waddr] <= bht_wdata;
        end
    end

    // Prediction select; returns win over calls, calls over branches.
    always_comb begin
        pred_taken  = 1'b0;
        pred_target = seq_pc;
        ras_pop     = 1'b0;
        if (f_is_ret) begin
            if (ras_cnt != '0) begin
                pred_taken  = 1'b1;
                pred_target = ras_top_c;
                ras_pop     = lookup;
            end
        end else if (f_is_call) begin
            pred_taken  = 1'b1;
            pred_target = f_target;
        end else if (f_is_br && f_ctr_msb) begin
            pred_taken  = 1'b1;
            pred_target = f_target;
        end
        ras_push = lookup && f_is_call;
    end

`ifdef BP_RAS_EN
    bp_ras #(
        .RAS_SIZE (RAS_SIZE),
        .ADDR_W   (ADDR_W)
    ) u_ras (
        .clk         (clk),
        .n_reset     (n_reset),
        .push        (ras_push),
        .pop         (ras_pop),
        .restore     (ras_restore),
        .push_data   (seq_pc),
        .restore_ptr (u_ras_ptr),
        .restore_cnt (u_ras_cnt),
        .top_c       (ras_top_c),
        .cnt         (ras_cnt),
        .ptr_nxt_c   (ras_ptr_nxt_c),
        .cnt_nxt_c   (ras_cnt_nxt_c)
    );
`else
    logic unused_ras;
    assign ras_top_c     = '0;
    assign ras_cnt       = '0;
    assign ras_ptr_nxt_c = '0;
    assign ras_cnt_nxt_c = '0;
    assign unused_ras    = ^{ras_push, ras_pop, ras_restore, u_ras_ptr, u_ras_cnt};
`endif

    // Registered prediction outputs and ready flag.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bp_ready  <= 1'b0;
            p_valid   <= 1'b0;
            p_taken   <= 1'b0;
            p_target  <= '0;
            p_ras_ptr <= '0;
            p_ras_cnt <= '0;
        end else begin
            bp_ready <= (state_d == BP_RUN);
            p_valid  <= lookup;
            if (lookup) begin
                p_taken   <= pred_taken;
                p_target  <= pred_target;
                p_ras_ptr <= ras_ptr_nxt_c;
                p_ras_cnt <= ras_cnt_nxt_c;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed, table-driven bench for branch_predictor (default parameters).
module tb_branch_predictor;

    localparam int unsigned BHT_SIZE = 256;
    localparam int unsigned CTR_BITS = 2;
    localparam int unsigned RAS_SIZE = 8;
    localparam int unsigned ADDR_W   = 48;
    localparam int unsigned PTR_W    = $clog2(RAS_SIZE);
    localparam int unsigned CNT_W    = PTR_W + 1;
`ifdef BP_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif
    localparam logic [ADDR_W-1:0] PC_MAX = {{(ADDR_W-2){1'b1}}, 2'b00};

    logic              clk, n_reset, bp_ready;
    logic              f_valid, f_is_br, f_is_call, f_is_ret;
    logic [ADDR_W-1:0] f_pc, f_target;
    logic              p_valid, p_taken;
    logic [ADDR_W-1:0] p_target;
    logic [PTR_W-1:0]  p_ras_ptr;
    logic [CNT_W-1:0]  p_ras_cnt;
    logic              u_valid, u_is_br, u_taken, u_mispredict;
    logic [ADDR_W-1:0] u_pc;
    logic [PTR_W-1:0]  u_ras_ptr;
    logic [CNT_W-1:0]  u_ras_cnt;

    branch_predictor #(
        .BHT_SIZE (BHT_SIZE),
        .CTR_BITS (CTR_BITS),
        .RAS_SIZE (RAS_SIZE),
        .ADDR_W   (ADDR_W)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .bp_ready     (bp_ready),
        .f_valid      (f_valid),
        .f_pc         (f_pc),
        .f_is_br      (f_is_br),
        .f_is_call    (f_is_call),
        .f_is_ret     (f_is_ret),
        .f_target     (f_target),
        .p_valid      (p_valid),
        .p_taken      (p_taken),
        .p_target     (p_target),
        .p_ras_ptr    (p_ras_ptr),
        .p_ras_cnt    (p_ras_cnt),
        .u_valid      (u_valid),
        .u_pc         (u_pc),
        .u_is_br      (u_is_br),
        .u_taken      (u_taken),
        .u_mispredict (u_mispredict),
        .u_ras_ptr    (u_ras_ptr),
        .u_ras_cnt    (u_ras_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic              f_valid;
        logic [ADDR_W-1:0] f_pc;
        logic              f_is_br;
        logic              f_is_call;
        logic              f_is_ret;
        logic [ADDR_W-1:0] f_target;
        logic              u_valid;
        logic [ADDR_W-1:0] u_pc;
        logic              u_is_br;
        logic              u_taken;
        logic              u_mispredict;
        logic [PTR_W-1:0]  u_rptr;
        logic [CNT_W-1:0]  u_rcnt;
        logic              e_valid;
        logic              e_taken;
        logic [ADDR_W-1:0] e_target;
        logic [CNT_W-1:0]  e_cnt;
    } vec_t;

    vec_t vecs [64];
    int   n_vec;
    int   n_tests;
    int   n_fail;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [CNT_W-1:0] ec(input int unsigned n);
        return RAS_ON ? CNT_W'(n) : '0;
    endfunction

    function automatic vec_t lk(input logic [ADDR_W-1:0] pc, input bit br, input bit call,
                                input bit ret, input logic [ADDR_W-1:0] tgt, input bit e_tk,
                                input logic [ADDR_W-1:0] e_tgt, input logic [CNT_W-1:0] e_c);
        vec_t v;
        v = '0;
        v.f_valid   = 1'b1;
        v.f_pc      = pc;
        v.f_is_br   = br;
        v.f_is_call = call;
        v.f_is_ret  = ret;
        v.f_target  = tgt;
        v.e_valid   = 1'b1;
        v.e_taken   = e_tk;
        v.e_target  = e_tgt;
        v.e_cnt     = e_c;
        return v;
    endfunction

    function automatic vec_t up(input logic [ADDR_W-1:0] pc, input bit tk);
        vec_t v;
        v = '0;
        v.u_valid = 1'b1;
        v.u_pc    = pc;
        v.u_is_br = 1'b1;
        v.u_taken = tk;
        return v;
    endfunction

    task automatic add_vec(input vec_t v);
        vecs[n_vec] = v;
        n_vec++;
    endtask

    task automatic apply(input vec_t v);
        f_valid      = v.f_valid;
        f_pc         = v.f_pc;
        f_is_br      = v.f_is_br;
        f_is_call    = v.f_is_call;
        f_is_ret     = v.f_is_ret;
        f_target     = v.f_target;
        u_valid      = v.u_valid;
        u_pc         = v.u_pc;
        u_is_br      = v.u_is_br;
        u_taken      = v.u_taken;
        u_mispredict = v.u_mispredict;
        u_ras_ptr    = v.u_rptr;
        u_ras_cnt    = v.u_rcnt;
    endtask

    // Drive one cycle at the falling edge, check the registered result one cycle later.
    task automatic run_vec(input vec_t v, input string name);
        apply(v);
        @(negedge clk);
        check({name, "_valid"}, 64'(p_valid), 64'(v.e_valid));
        if (v.e_valid) begin
            check({name, "_taken"}, 64'(p_taken), 64'(v.e_taken));
            check({name, "_target"}, 64'(p_target), 64'(v.e_target));
            check({name, "_cnt"}, 64'(p_ras_cnt), 64'(v.e_cnt));
        end
    endtask

    // Release reset and walk the init sweep while throwing requests that must be ignored.
    task automatic run_init();
        vec_t j;
        vec_t z;
        z = '0;
        j = lk(48'h1000, 1'b1, 1'b1, 1'b0, 48'h2000, 1'b0, '0, '0);
        j.u_valid = 1'b1;
        j.u_pc    = 48'h1000;
        j.u_is_br = 1'b1;
        j.u_taken = 1'b1;
        j.u_rcnt  = CNT_W'(3);
        n_reset = 1'b1;
        apply(j);
        for (int k = 1; k <= int'(BHT_SIZE); k++) begin
            @(negedge clk);
            if (k < int'(BHT_SIZE)) begin
                check($sformatf("init_ready_low_c%0d", k), 64'(bp_ready), 64'd0);
                check($sformatf("init_pvalid_c%0d", k), 64'(p_valid), 64'd0);
                j.u_mispredict = k[0];
                apply(j);
            end else begin
                check("init_ready_high", 64'(bp_ready), 64'd1);
                check("init_done_pvalid", 64'(p_valid), 64'd0);
                check("init_done_cnt", 64'(p_ras_cnt), 64'd0);
                apply(z);
            end
        end
    endtask

    initial begin
        vec_t v;
        vec_t z;
        logic [PTR_W-1:0] ck_ptr;
        logic [CNT_W-1:0] ck_cnt;

        n_tests = 0;
        n_fail  = 0;
        n_vec   = 0;
        z       = '0;

        // BHT training, saturation, wrap and same-cycle hazard.
        add_vec(lk(48'h1000, 1'b1, 1'b0, 1'b0, 48'h2000, 1'b0, 48'h1004, ec(0)));
        add_vec(up(48'h1000, 1'b1));
        add_vec(up(48'h1000, 1'b1));
        add_vec(lk(48'h1000, 1'b1, 1'b0, 1'b0, 48'h2000, 1'b1, 48'h2000, ec(0)));
        add_vec(up(48'h1000, 1'b1));
        add_vec(up(48'h1000, 1'b1));
        add_vec(up(48'h1000, 1'b0));
        add_vec(lk(48'h1000, 1'b1, 1'b0, 1'b0, 48'h2000, 1'b1, 48'h2000, ec(0)));
        add_vec(up(48'h1000, 1'b0));
        add_vec(lk(48'h1000, 1'b1, 1'b0, 1'b0, 48'h2000, 1'b0, 48'h1004, ec(0)));
        add_vec(lk(48'h3000, 1'b0, 1'b0, 1'b0, 48'h9000, 1'b0, 48'h3004, ec(0)));
        add_vec(lk(PC_MAX, 1'b0, 1'b0, 1'b0, 48'h9000, 1'b0, 48'h0, ec(0)));
        v = lk(48'h14, 1'b1, 1'b0, 1'b0, 48'h5000, 1'b0, 48'h18, ec(0));
        v.u_valid = 1'b1;
        v.u_pc    = 48'h14;
        v.u_is_br = 1'b1;
        v.u_taken = 1'b1;
        add_vec(v);
        add_vec(lk(48'h14, 1'b1, 1'b0, 1'b0, 48'h5000, 1'b1, 48'h5000, ec(0)));
        v = up(48'h14, 1'b0);
        v.u_is_br = 1'b0;
        add_vec(v);
        add_vec(lk(48'h414, 1'b1, 1'b0, 1'b0, 48'h6000, 1'b1, 48'h6000, ec(0)));
        // Calls and returns, including underflow.
        add_vec(lk(48'h100, 1'b0, 1'b1, 1'b0, 48'h800, 1'b1, 48'h800, ec(1)));
        add_vec(lk(48'h200, 1'b0, 1'b1, 1'b0, 48'h900, 1'b1, 48'h900, ec(2)));
        add_vec(lk(48'h300, 1'b0, 1'b0, 1'b1, 48'h0, RAS_ON, RAS_ON ? 48'h204 : 48'h304, ec(1)));
        add_vec(lk(48'h300, 1'b0, 1'b0, 1'b1, 48'h0, RAS_ON, RAS_ON ? 48'h104 : 48'h304, ec(0)));
        add_vec(lk(48'h300, 1'b0, 1'b0, 1'b1, 48'h0, 1'b0, 48'h304, ec(0)));
        // Overflow: nine calls into an eight-entry stack, then nine returns.
        for (int i = 0; i < 9; i++) begin
            add_vec(lk(ADDR_W'(i * 16), 1'b0, 1'b1, 1'b0, 48'h4000, 1'b1, 48'h4000,
                       ec(i < 8 ? i + 1 : 8)));
        end
        for (int j = 0; j < 9; j++) begin
            add_vec(lk(48'h600, 1'b0, 1'b0, 1'b1, 48'h0, RAS_ON && (j < 8),
                       (RAS_ON && (j < 8)) ? ADDR_W'(32'h84 - 16 * j) : 48'h604,
                       ec(j < 8 ? 7 - j : 0)));
        end
        // Call+return on an empty stack: not taken, but the push happens.
        add_vec(lk(48'h700, 1'b0, 1'b1, 1'b1, 48'hAAA0, 1'b0, 48'h704, ec(1)));
        add_vec(lk(48'h600, 1'b0, 1'b0, 1'b1, 48'h0, RAS_ON, RAS_ON ? 48'h704 : 48'h604, ec(0)));

        // Reset state.
        n_reset = 1'b0;
        apply(z);
        repeat (3) @(negedge clk);
        check("rst_ready", 64'(bp_ready), 64'd0);
        check("rst_pvalid", 64'(p_valid), 64'd0);
        check("rst_ptaken", 64'(p_taken), 64'd0);
        check("rst_ptarget", 64'(p_target), 64'd0);
        check("rst_ptr", 64'(p_ras_ptr), 64'd0);
        check("rst_cnt", 64'(p_ras_cnt), 64'd0);

        run_init();

        for (int i = 0; i < n_vec; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Misprediction restore with a dropped same-cycle lookup and a live BHT update.
        run_vec(lk(48'hA00, 1'b0, 1'b1, 1'b0, 48'hB00, 1'b1, 48'hB00, ec(1)), "mp_call0");
        ck_ptr = p_ras_ptr;
        ck_cnt = p_ras_cnt;
        run_vec(lk(48'hC00, 1'b0, 1'b1, 1'b0, 48'hC80, 1'b1, 48'hC80, ec(2)), "mp_call1");
        run_vec(lk(48'hD00, 1'b0, 1'b1, 1'b0, 48'hD80, 1'b1, 48'hD80, ec(3)), "mp_call2");
        v = lk(48'hE00, 1'b0, 1'b1, 1'b0, 48'hE80, 1'b0, '0, '0);
        v.e_valid      = 1'b0;
        v.u_valid      = 1'b1;
        v.u_pc         = 48'h1000;
        v.u_is_br      = 1'b1;
        v.u_taken      = 1'b1;
        v.u_mispredict = 1'b1;
        v.u_rptr       = ck_ptr;
        v.u_rcnt       = ck_cnt;
        run_vec(v, "mp_flush");
        run_vec(lk(48'hF00, 1'b0, 1'b0, 1'b1, 48'h0, RAS_ON, RAS_ON ? 48'hA04 : 48'hF04, ec(0)),
                "mp_ret");
        run_vec(lk(48'h1000, 1'b1, 1'b0, 1'b0, 48'h2000, 1'b1, 48'h2000, ec(0)), "mp_bht");

        // Asynchronous reset in the middle of operation.
        run_vec(lk(48'h100, 1'b0, 1'b1, 1'b0, 48'h800, 1'b1, 48'h800, ec(1)), "pre_rst");
        #2 n_reset = 1'b0;
        #1;
        check("mid_rst_ready", 64'(bp_ready), 64'd0);
        check("mid_rst_pvalid", 64'(p_valid), 64'd0);
        check("mid_rst_ptaken", 64'(p_taken), 64'd0);
        check("mid_rst_ptarget", 64'(p_target), 64'd0);
        check("mid_rst_ptr", 64'(p_ras_ptr), 64'd0);
        check("mid_rst_cnt", 64'(p_ras_cnt), 64'd0);
        apply(z);
        @(negedge clk);
        run_init();
        run_vec(lk(48'h1000, 1'b1, 1'b0, 1'b0, 48'h2000, 1'b0, 48'h1004, ec(0)), "post_rst_bht");
        run_vec(lk(48'h600, 1'b0, 1'b0, 1'b1, 48'h0, 1'b0, 48'h604, ec(0)), "post_rst_ret");
        run_vec(lk(48'h200, 1'b0, 1'b1, 1'b0, 48'h900, 1'b1, 48'h900, ec(1)), "post_rst_call");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
